// File: rtl/mean_seq_ctrl.sv
// Sequencer for the mean-calculation datapath: start/release handshake, ROM word
// stepping, accumulator clear/enable and mean-load strobes, ready/done status.
module mean_seq_ctrl #(
  parameter int N_WORDS = 32,
  parameter int ADDR_W  = 6,
  parameter int SHIFT   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              mean_ld,
  output logic              done,
  output logic [2:0]        state_dbg
);

  // The datapath divides by shifting, so the word count must be a power of two.
  if (N_WORDS != (1 << SHIFT)) begin : g_bad_shift
    $error("mean_seq_ctrl: N_WORDS must equal 2**SHIFT");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REL = 3'd1,
    INIT     = 3'd2,
    ACCUM    = 3'd3,
    DIV      = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N_WORDS);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= FIRST;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Handshake: start is a level request. IDLE (ready=1) takes it when high,
  // WAIT_REL holds until it falls, and only then does a run begin. Start is
  // not looked at again until the run has returned to IDLE.
  always_comb begin
    state_nxt = IDLE;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    mean_ld   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready     = 1'b1;
        state_nxt = start ? WAIT_REL : IDLE;
      end
      WAIT_REL: begin
        state_nxt = start ? WAIT_REL : INIT;
      end
      INIT: begin
        acc_clr   = 1'b1;
        cnt_nxt   = FIRST;
        state_nxt = ACCUM;
      end
      ACCUM: begin
        acc_en = 1'b1;
        // Any cnt at or past the last word ends the run, so cnt cannot wrap.
        if (cnt < LAST) begin
          cnt_nxt   = cnt + FIRST;
          state_nxt = ACCUM;
        end else begin
          state_nxt = DIV;
        end
      end
      DIV: begin
        mean_ld   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rom_addr  = cnt;
  assign state_dbg = state;

endmodule

// File: tb/tb_mean_seq_ctrl.sv
// Bench for mean_seq_ctrl: a 32-word and an 8-word instance, a run-timeline model
// checked every cycle, and a small behavioural datapath to recover the mean.
module tb_mean_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic       ready0, acc_clr0, acc_en0, mean_ld0, done0;
  logic [5:0] rom_addr0;
  logic [2:0] sd0;
  logic       ready1, acc_clr1, acc_en1, mean_ld1, done1;
  logic [3:0] rom_addr1;
  logic [2:0] sd1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mean_seq_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start0), .ready(ready0), .rom_addr(rom_addr0),
    .acc_clr(acc_clr0), .acc_en(acc_en0), .mean_ld(mean_ld0), .done(done0), .state_dbg(sd0)
  );

  mean_seq_ctrl #(.N_WORDS(8), .ADDR_W(4), .SHIFT(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ready(ready1), .rom_addr(rom_addr1),
    .acc_clr(acc_clr1), .acc_en(acc_en1), .mean_ld(mean_ld1), .done(done1), .state_dbg(sd1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // A run is a timeline: phase -2 idle, -1 waiting for release, then phase t
  // counts cycles since the run began: 0 clear, 1..N add word t, N+1 load, N+2 done.
  int ph0 = -2, ph1 = -2;
  int ma0 = 1, ma1 = 1;
  int acc0 = 0, acc1 = 0, mean0 = 0, mean1 = 0;

  function automatic int nxt_ph(input int p, input logic s, input int n);
    if (p == -2) return s ? -1 : -2;
    if (p == -1) return s ? -1 : 0;
    if (p == n + 2) return -2;
    return p + 1;
  endfunction

  // The address shows the word being added; outside the add window it keeps
  // the last word used (1 straight after reset).
  function automatic int nxt_addr(input int p_next, input int a, input int n);
    return (p_next >= 1 && p_next <= n) ? p_next : a;
  endfunction

  function automatic logic [10:0] exp_vec(input int p, input int a, input int n);
    logic [5:0] a6;
    a6 = 6'(a);
    return {p == -2, p == 0, (p >= 1 && p <= n), p == n + 1, p == n + 2, a6};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph0 <= -2; ph1 <= -2;
      ma0 <= 1;  ma1 <= 1;
    end else begin
      ph0 <= nxt_ph(ph0, start0, 32);
      ph1 <= nxt_ph(ph1, start1, 8);
      ma0 <= nxt_addr(nxt_ph(ph0, start0, 32), ma0, 32);
      ma1 <= nxt_addr(nxt_ph(ph1, start1, 8), ma1, 8);
      // Datapath with ROM[i] = i-1 attached to each controller.
      acc0  <= acc_clr0 ? 0 : (acc_en0 ? acc0 + int'(rom_addr0) - 1 : acc0);
      acc1  <= acc_clr1 ? 0 : (acc_en1 ? acc1 + int'(rom_addr1) - 1 : acc1);
      mean0 <= mean_ld0 ? (acc0 >> 5) : mean0;
      mean1 <= mean_ld1 ? (acc1 >> 3) : mean1;
    end
  end

  // ---------------- scoreboard / compare ----------------
  int k0 = 0, k1 = 0;
  int en0 = 0, ld0 = 0, en1 = 0, ld1 = 0;
  int done_cnt0 = 0, done_cnt1 = 0;

  // Cycles are numbered by the edge that closes them; k is the edge that
  // samples start=0 in WAIT_REL.
  always @(negedge clk) begin
    chk("outputs_n32", {21'd0, ready0, acc_clr0, acc_en0, mean_ld0, done0, rom_addr0},
        {21'd0, exp_vec(ph0, ma0, 32)});
    chk("outputs_n8", {21'd0, ready1, acc_clr1, acc_en1, mean_ld1, done1, 2'b00, rom_addr1},
        {21'd0, exp_vec(ph1, ma1, 8)});
    en0 <= acc_clr0 ? 0 : (acc_en0 ? en0 + 1 : en0);
    ld0 <= acc_clr0 ? 0 : (mean_ld0 ? ld0 + 1 : ld0);
    en1 <= acc_clr1 ? 0 : (acc_en1 ? en1 + 1 : en1);
    ld1 <= acc_clr1 ? 0 : (mean_ld1 ? ld1 + 1 : ld1);
    if (done0) begin
      done_cnt0 <= done_cnt0 + 1;
      chk("done_cycle_n32", cyc + 1, k0 + 35);
      chk("acc_en_cycles_n32", en0, 32);
      chk("mean_ld_cycles_n32", ld0, 1);
      chk("mean_n32", mean0, 15);
    end
    if (done1) begin
      done_cnt1 <= done_cnt1 + 1;
      chk("done_cycle_n8", cyc + 1, k1 + 11);
      chk("acc_en_cycles_n8", en1, 8);
      chk("mean_ld_cycles_n8", ld1, 1);
      chk("mean_n8", mean1, 3);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int i, input string name);
    int t = 0;
    @(negedge clk);
    while (((i == 0) ? done0 : done1) !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, (i == 0) ? done0 : done1, 1);
  endtask

  task automatic wait_addr0(input int a, input string name);
    int t = 0;
    while (!(acc_en0 === 1'b1 && int'(rom_addr0) == a) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, rom_addr0, a);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dc;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready0, 1);
    chk("reset_rom_addr", rom_addr0, 1);
    chk("reset_strobes", {acc_clr0, acc_en0, mean_ld0, done0}, 0);
    chk("reset_state_n32", sd0, 0);
    chk("reset_state_n8", sd1, 0);
    rst = 1'b1;

    // Nominal run: start high for two samples, then released.
    @(negedge clk);
    start0 = 1'b1;
    repeat (2) @(negedge clk);
    start0 = 1'b0;
    k0 = cyc + 1;
    wait_done(0, "nominal_done");

    // Reset in the middle of the add window.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k0 = cyc + 1;
    wait_addr0(17, "reach_addr17");
    dc = done_cnt0;
    #2 rst = 1'b0;
    #1;
    chk("midrun_reset_ready", ready0, 1);
    chk("midrun_reset_rom_addr", rom_addr0, 1);
    chk("midrun_reset_acc_en", acc_en0, 0);
    chk("midrun_reset_done", done0, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_after_reset", done_cnt0, dc);

    // Start held for ten cycles: the run must wait for release.
    start0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("held_no_clear", acc_clr0, 0);
    chk("held_not_ready", ready0, 0);
    start0 = 1'b0;
    k0 = cyc + 1;
    wait_done(0, "held_done");

    // Start pulsed during the add window is ignored.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k0 = cyc + 1;
    wait_addr0(5, "reach_addr5");
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, "pulse_done");

    // Back-to-back: start raised at done and kept through the following idle cycle.
    start0 = 1'b1;
    repeat (2) @(negedge clk);
    start0 = 1'b0;
    k0 = cyc + 1;
    wait_done(0, "b2b_done");

    // Eight-word instance.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k1 = cyc + 1;
    wait_done(1, "n8_done");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
